// File: rtl/serial_adder.sv
// Bit-serial adder: adds two WIDTH-bit operands LSB first, one full-adder step per clock.
// Optional two's-complement overflow output enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] acc;
  logic             cy;
  logic [CW-1:0]    cnt;
  logic             accept;
  logic             last;
  logic             hs;
  logic             hc;
  logic             fs;
  logic             fc;

  assign accept = start && (state != SHIFT);
  assign last   = (state == SHIFT) && (cnt == CW'(WIDTH - 1));

  // Half adder on the operand LSBs, widened to a full adder by the carry register
  assign hs = sa[0] ^ sb[0];
  assign hc = sa[0] & sb[0];
  assign fs = hs ^ cy;
  assign fc = hc | (hs & cy);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SHIFT;
      SHIFT:   if (last) state_nxt = DONE;
      DONE:    state_nxt = accept ? SHIFT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      SHIFT:   busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sa    <= '0;
      sb    <= '0;
      acc   <= '0;
      cy    <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      carry <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf   <= 1'b0;
`endif
    end else if (accept) begin
      sa  <= a;
      sb  <= b;
      acc <= '0;
      cy  <= 1'b0;
      cnt <= '0;
    end else if (state == SHIFT) begin
      sa  <= sa >> 1;
      sb  <= sb >> 1;
      acc <= {fs, acc[WIDTH-1:1]};
      cy  <= fc;
      cnt <= cnt + CW'(1);
      // Result registers move only on the final bit; cy still holds the carry into the MSB
      if (last) begin
        sum   <= {fs, acc[WIDTH-1:1]};
        carry <= fc;
`ifdef SERIAL_ADDER_OVF_EN
        ovf   <= cy ^ fc;
`endif
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder (WIDTH=8); ovf checks follow SERIAL_ADDER_OVF_EN.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         carry;
`ifdef SERIAL_ADDER_OVF_EN
  logic         ovf;
`endif

  int checks;
  int failures;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .carry (carry)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands with start for one edge; returns just after the accepting edge
  task automatic launch(input logic [W-1:0] va, input logic [W-1:0] vb);
    a = va;
    b = vb;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    #2;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (sum !== 8'h00) begin failures++; $display("FAIL reset_sum got=%h exp=00", sum); end
    checks++; if (carry !== 1'b0) begin failures++; $display("FAIL reset_carry got=%b exp=0", carry); end
`ifdef SERIAL_ADDER_OVF_EN
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
`endif
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_basic();
    launch(8'h0F, 8'h01);
    for (int i = 0; i < W; i++) begin
      if (i > 0) tick();
      checks++; if (busy !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL basic_busy edge=%0d got busy=%b done=%b exp busy=1 done=0", i, busy, done); end
      checks++; if (sum !== 8'h00) begin failures++; $display("FAIL basic_sum_stable edge=%0d got=%h exp=00", i, sum); end
    end
    tick();
    checks++; if (done !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL basic_done got done=%b busy=%b exp done=1 busy=0", done, busy); end
    checks++; if (sum !== 8'h10) begin failures++; $display("FAIL basic_sum got=%h exp=10", sum); end
    checks++; if (carry !== 1'b0) begin failures++; $display("FAIL basic_carry got=%b exp=0", carry); end
`ifdef SERIAL_ADDER_OVF_EN
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL basic_ovf got=%b exp=0", ovf); end
`endif
    tick();
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL basic_pulse got done=%b busy=%b exp done=0 busy=0", done, busy); end
    checks++; if (sum !== 8'h10) begin failures++; $display("FAIL basic_hold got=%h exp=10", sum); end
  endtask

  task automatic test_carry();
    launch(8'hFF, 8'h01);
    repeat (W) tick();
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL carry1_done got=%b exp=1", done); end
    checks++; if (sum !== 8'h00 || carry !== 1'b1) begin failures++; $display("FAIL carry1_result got sum=%h carry=%b exp sum=00 carry=1", sum, carry); end
`ifdef SERIAL_ADDER_OVF_EN
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL carry1_ovf got=%b exp=0", ovf); end
`endif
    tick();
    launch(8'hAA, 8'h55);
    repeat (W) tick();
    checks++; if (sum !== 8'hFF || carry !== 1'b0) begin failures++; $display("FAIL alt_result got sum=%h carry=%b exp sum=ff carry=0", sum, carry); end
`ifdef SERIAL_ADDER_OVF_EN
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL alt_ovf got=%b exp=0", ovf); end
`endif
    tick();
    launch(8'h7F, 8'h01);
    repeat (W) tick();
    checks++; if (sum !== 8'h80 || carry !== 1'b0) begin failures++; $display("FAIL ovf_result got sum=%h carry=%b exp sum=80 carry=0", sum, carry); end
`ifdef SERIAL_ADDER_OVF_EN
    checks++; if (ovf !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b exp=1", ovf); end
`endif
    tick();
  endtask

  task automatic test_hold_start();
    a = 8'h25;
    b = 8'h13;
    start = 1'b1;
    tick();
    for (int i = 1; i < W; i++) begin
      a = 8'(i * 37);
      b = 8'hFF;
      tick();
      checks++; if (busy !== 1'b1 || sum !== 8'h80) begin failures++; $display("FAIL hold_shift edge=%0d got busy=%b sum=%h exp busy=1 sum=80", i, busy, sum); end
    end
    tick();
    checks++; if (done !== 1'b1 || sum !== 8'h38 || carry !== 1'b0) begin failures++; $display("FAIL hold_result got done=%b sum=%h carry=%b exp done=1 sum=38 carry=0", done, sum, carry); end
    start = 1'b0;
    tick();
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL hold_noqueue got busy=%b done=%b exp busy=0 done=0", busy, done); end
  endtask

  task automatic test_reset_mid();
    bit seen_done;
    launch(8'h11, 8'h22);
    repeat (4) tick();
    rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL midrst_ctrl got busy=%b done=%b exp busy=0 done=0", busy, done); end
    checks++; if (sum !== 8'h00 || carry !== 1'b0) begin failures++; $display("FAIL midrst_data got sum=%h carry=%b exp sum=00 carry=0", sum, carry); end
    tick();
    rst = 1'b0;
    seen_done = 1'b0;
    for (int i = 0; i < W + 2; i++) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) seen_done = 1'b1;
    end
    checks++; if (seen_done !== 1'b0) begin failures++; $display("FAIL midrst_abort got activity=%b exp=0", seen_done); end
    launch(8'h03, 8'h05);
    repeat (W) tick();
    checks++; if (done !== 1'b1 || sum !== 8'h08 || carry !== 1'b0) begin failures++; $display("FAIL midrst_clean got done=%b sum=%h carry=%b exp done=1 sum=08 carry=0", done, sum, carry); end
    tick();
  endtask

  task automatic test_back_to_back();
    launch(8'h01, 8'h02);
    repeat (W) tick();
    checks++; if (done !== 1'b1 || sum !== 8'h03) begin failures++; $display("FAIL b2b_first got done=%b sum=%h exp done=1 sum=03", done, sum); end
    launch(8'h80, 8'h80);
    checks++; if (busy !== 1'b1 || done !== 1'b0 || sum !== 8'h03) begin failures++; $display("FAIL b2b_restart got busy=%b done=%b sum=%h exp busy=1 done=0 sum=03", busy, done, sum); end
    repeat (W - 1) tick();
    checks++; if (busy !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL b2b_last_shift got busy=%b done=%b exp busy=1 done=0", busy, done); end
    tick();
    checks++; if (done !== 1'b1 || sum !== 8'h00 || carry !== 1'b1) begin failures++; $display("FAIL b2b_second got done=%b sum=%h carry=%b exp done=1 sum=00 carry=1", done, sum, carry); end
`ifdef SERIAL_ADDER_OVF_EN
    checks++; if (ovf !== 1'b1) begin failures++; $display("FAIL b2b_ovf got=%b exp=1", ovf); end
`endif
    tick();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_basic();
    test_carry();
    test_hold_start();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
